// File: rtl/game_sequencer_if.sv
// Board/RNG/spawn handshake bundle between the game sequencer (master)
// and the board datapath plus random source (slave).
interface game_sequencer_if #(
  parameter int BOARD_DIM = 4,
  parameter int TILE_W    = 4,
  parameter int LOC_W     = $clog2(BOARD_DIM * BOARD_DIM)
);
  logic              rng_req;
  logic              rng_valid;
  logic [LOC_W-1:0]  rng_location;
  logic              rng_four;
  logic              move_req;
  logic [3:0]        move_dir;
  logic              board_done;
  logic              board_changed;
  logic              movable;
  logic [LOC_W:0]    empty_count;
  logic [TILE_W-1:0] max_tile;
  logic              spawn_valid;
  logic [LOC_W-1:0]  spawn_location;
  logic [TILE_W-1:0] spawn_value;

  modport master (
    output rng_req, move_req, move_dir, spawn_valid, spawn_location, spawn_value,
    input  rng_valid, rng_location, rng_four, board_done, board_changed,
           movable, empty_count, max_tile
  );

  modport slave (
    input  rng_req, move_req, move_dir, spawn_valid, spawn_location, spawn_value,
    output rng_valid, rng_location, rng_four, board_done, board_changed,
           movable, empty_count, max_tile
  );
endinterface

// File: rtl/game_sequencer.sv
// Top-level 2048 game sequencer: tile spawning, button-driven moves with
// timeout, win/lose detection. All outputs are registered.
module game_sequencer #(
  parameter int BOARD_DIM    = 4,
  parameter int TILE_W       = 4,
  parameter int INIT_TILES   = 2,
  parameter int WIN_EXP      = 11,
  parameter int MOVE_TIMEOUT = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [3:0]            button_press,
  game_sequencer_if.master      bus,
  output logic [2:0]            game_state,
  output logic [15:0]           move_count,
  output logic                  timeout_err
);
  localparam int LOC_W = $clog2(BOARD_DIM * BOARD_DIM);
  localparam int TMR_W = $clog2(MOVE_TIMEOUT + 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    INIT  = 3'd1,
    CHECK = 3'd2,
    WAIT  = 3'd3,
    MOVE  = 3'd4,
    SPAWN = 3'd5,
    WON   = 3'd6,
    LOST  = 3'd7
  } state_t;

  state_t            state_r;
  logic [3:0]        btn_d1_r;
  logic [3:0]        btn_d2_r;
  logic [3:0]        edge_r;
  logic [3:0]        move_dir_r;
  logic [LOC_W:0]    spawn_cnt_r;
  logic [LOC_W:0]    spawn_target_s;
  logic [TMR_W-1:0]  timer_r;
  logic [15:0]       move_count_r;
  logic              won_latched_r;
  logic              timeout_err_r;
  logic              rng_req_r;
  logic              move_req_r;
  logic              spawn_valid_r;
  logic [LOC_W-1:0]  spawn_location_r;
  logic [TILE_W-1:0] spawn_value_r;

  function automatic logic is_onehot4(input logic [3:0] v);
    return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
  endfunction

  // Number of spawns the current spawning state must perform
  always_comb begin
    spawn_target_s = (LOC_W+1)'(1);
    if (state_r == INIT) begin
      spawn_target_s = (LOC_W+1)'(INIT_TILES);
    end else begin
      spawn_target_s = (LOC_W+1)'(1);
    end
  end

  // Game FSM, button edge pipeline and all registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r          <= IDLE;
      btn_d1_r         <= 4'd0;
      btn_d2_r         <= 4'd0;
      edge_r           <= 4'd0;
      move_dir_r       <= 4'd0;
      spawn_cnt_r      <= '0;
      timer_r          <= '0;
      move_count_r     <= 16'd0;
      won_latched_r    <= 1'b0;
      timeout_err_r    <= 1'b0;
      rng_req_r        <= 1'b0;
      move_req_r       <= 1'b0;
      spawn_valid_r    <= 1'b0;
      spawn_location_r <= '0;
      spawn_value_r    <= '0;
    end else begin
      btn_d1_r <= button_press;
      btn_d2_r <= btn_d1_r;
      edge_r   <= btn_d1_r & ~btn_d2_r;
      case (state_r)
        IDLE, LOST: begin
          if (start) begin
            state_r       <= INIT;
            spawn_cnt_r   <= '0;
            move_count_r  <= 16'd0;
            won_latched_r <= 1'b0;
            timeout_err_r <= 1'b0;
          end
        end
        // Phases: decide (no req, no pulse) -> request -> spawn pulse -> decide
        INIT, SPAWN: begin
          if (spawn_valid_r) begin
            spawn_valid_r <= 1'b0;
          end else if (rng_req_r) begin
            if (bus.rng_valid) begin
              rng_req_r        <= 1'b0;
              spawn_valid_r    <= 1'b1;
              spawn_location_r <= bus.rng_location;
              spawn_value_r    <= bus.rng_four ? TILE_W'(2) : TILE_W'(1);
              spawn_cnt_r      <= spawn_cnt_r + (LOC_W+1)'(1);
            end
          end else if ((spawn_cnt_r >= spawn_target_s) || (bus.empty_count == '0)) begin
            state_r <= CHECK;
          end else begin
            rng_req_r <= 1'b1;
          end
        end
        CHECK: begin
          if ((int'(bus.max_tile) >= WIN_EXP) && !won_latched_r) begin
            state_r <= WON;
          end else if (!bus.movable) begin
            state_r <= LOST;
          end else begin
            state_r <= WAIT;
          end
        end
        WAIT: begin
          if (is_onehot4(edge_r)) begin
            state_r    <= MOVE;
            move_req_r <= 1'b1;
            move_dir_r <= edge_r;
            timer_r    <= '0;
          end
        end
        MOVE: begin
          if (bus.board_done) begin
            move_req_r <= 1'b0;
            move_dir_r <= 4'd0;
            if (bus.board_changed) begin
              state_r     <= SPAWN;
              spawn_cnt_r <= '0;
              if (move_count_r != 16'hFFFF) begin
                move_count_r <= move_count_r + 16'd1;
              end
            end else begin
              state_r <= WAIT;
            end
          end else if (timer_r == TMR_W'(MOVE_TIMEOUT - 1)) begin
            timeout_err_r <= 1'b1;
            move_req_r    <= 1'b0;
            move_dir_r    <= 4'd0;
            state_r       <= WAIT;
          end else begin
            timer_r <= timer_r + TMR_W'(1);
          end
        end
        WON: begin
          if (start) begin
            won_latched_r <= 1'b1;
            state_r       <= WAIT;
          end
        end
        default: state_r <= IDLE;
      endcase
    end
  end

  assign bus.rng_req        = rng_req_r;
  assign bus.move_req       = move_req_r;
  assign bus.move_dir       = move_dir_r;
  assign bus.spawn_valid    = spawn_valid_r;
  assign bus.spawn_location = spawn_location_r;
  assign bus.spawn_value    = spawn_value_r;
  assign game_state         = state_r;
  assign move_count         = move_count_r;
  assign timeout_err        = timeout_err_r;
endmodule

// File: tb/tb_game_sequencer.sv
// Directed self-checking bench for game_sequencer with hand-computed expectations.
module tb_game_sequencer;
  logic        clk;
  logic        rst;
  logic        start;
  logic [3:0]  button_press;
  logic [2:0]  game_state;
  logic [15:0] move_count;
  logic        timeout_err;
  int          n_tests;
  int          n_fail;

  game_sequencer_if bus ();

  game_sequencer dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .button_press (button_press),
    .bus          (bus),
    .game_state   (game_state),
    .move_count   (move_count),
    .timeout_err  (timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_state(input logic [2:0] s, input string tag);
    int n = 0;
    while (game_state !== s && n < 20) begin
      tick();
      n++;
    end
    chk(tag, 32'(game_state), 32'(s));
  endtask

  task automatic do_spawn(input logic [3:0] loc, input logic four, input string tag);
    int n = 0;
    while (bus.rng_req !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    chk({tag, "_req"}, 32'(bus.rng_req), 32'd1);
    tick();
    bus.rng_valid    = 1'b1;
    bus.rng_location = loc;
    bus.rng_four     = four;
    tick();
    bus.rng_valid = 1'b0;
    chk({tag, "_pulse"}, {29'd0, bus.spawn_valid, bus.rng_req, 1'b0}, 32'b100);
    chk({tag, "_loc_val"}, {bus.spawn_location, bus.spawn_value}, {loc, four ? 4'd2 : 4'd1});
    tick();
    chk({tag, "_pulse_end"}, 32'(bus.spawn_valid), 32'd0);
  endtask

  task automatic press(input logic [3:0] b, input string tag);
    int n = 0;
    button_press = b;
    while (bus.move_req !== 1'b1 && n < 10) begin
      tick();
      n++;
    end
    button_press = 4'd0;
    chk({tag, "_move"}, {27'd0, bus.move_req, bus.move_dir}, {27'd0, 1'b1, b});
  endtask

  task automatic done_pulse(input logic changed);
    bus.board_done    = 1'b1;
    bus.board_changed = changed;
    tick();
    bus.board_done    = 1'b0;
    bus.board_changed = 1'b0;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst = 1'b1;
    start = 1'b0;
    button_press = 4'd0;
    bus.rng_valid = 1'b0;
    bus.rng_location = 4'd0;
    bus.rng_four = 1'b0;
    bus.board_done = 1'b0;
    bus.board_changed = 1'b0;
    bus.movable = 1'b1;
    bus.empty_count = 5'd16;
    bus.max_tile = 4'd1;
    tick();
    tick();
    chk("reset_outs", {game_state, bus.rng_req, bus.move_req, bus.spawn_valid, timeout_err, move_count},
        32'd0);
    rst = 1'b0;

    // Game start with two spawns
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("init_entry", 32'(game_state), 32'd1);
    do_spawn(4'd5, 1'b0, "spawn1");
    do_spawn(4'd9, 1'b1, "spawn2");
    wait_state(3'd3, "init_to_wait");

    // Left press, board changes
    press(4'b0010, "left");
    chk("move_state", 32'(game_state), 32'd4);
    done_pulse(1'b1);
    chk("move_to_spawn", {13'd0, game_state, move_count}, {13'd0, 3'd5, 16'd1});
    do_spawn(4'd3, 1'b0, "spawn3");
    wait_state(3'd3, "spawn_to_wait");

    // Simultaneous up+right is discarded
    button_press = 4'b1001;
    repeat (6) tick();
    chk("multi_edge", {28'd0, game_state, bus.move_req}, {28'd0, 3'd3, 1'b0});
    button_press = 4'd0;
    repeat (3) tick();
    press(4'b0100, "down");
    done_pulse(1'b0);
    chk("nochange_move", {13'd0, game_state, move_count}, {13'd0, 3'd3, 16'd1});

    // Win path, spawn skipped on full board
    bus.max_tile = 4'd11;
    bus.empty_count = 5'd0;
    press(4'b0001, "right");
    done_pulse(1'b1);
    chk("full_spawn", 32'(game_state), 32'd5);
    tick();
    chk("full_to_check", {28'd0, game_state, bus.rng_req}, {28'd0, 3'd2, 1'b0});
    tick();
    chk("won", {13'd0, game_state, move_count}, {13'd0, 3'd6, 16'd2});
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("won_continue", 32'(game_state), 32'd3);
    press(4'b1000, "up");
    done_pulse(1'b1);
    tick();
    chk("check_after_win", 32'(game_state), 32'd2);
    tick();
    chk("no_rewin", 32'(game_state), 32'd3);
    bus.movable = 1'b0;
    press(4'b0100, "down2");
    done_pulse(1'b1);
    tick();
    tick();
    chk("lost", {13'd0, game_state, move_count}, {13'd0, 3'd7, 16'd4});

    // Restart from LOST
    bus.movable = 1'b1;
    bus.max_tile = 4'd1;
    bus.empty_count = 5'd16;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("restart", {13'd0, game_state, move_count}, {13'd0, 3'd1, 16'd0});
    do_spawn(4'd0, 1'b0, "spawn4");
    do_spawn(4'd15, 1'b1, "spawn5");
    wait_state(3'd3, "restart_wait");

    // Stray handshakes outside their consuming states
    bus.rng_valid = 1'b1;
    bus.board_done = 1'b1;
    bus.board_changed = 1'b1;
    tick();
    bus.rng_valid = 1'b0;
    bus.board_done = 1'b0;
    bus.board_changed = 1'b0;
    chk("stray_ignored", {12'd0, game_state, bus.spawn_valid, move_count}, {12'd0, 3'd3, 1'b0, 16'd0});

    // Timeout at exactly 255 cycles in MOVE
    press(4'b0010, "to_left");
    repeat (254) tick();
    chk("before_timeout", {30'd0, bus.move_req, timeout_err}, {30'd0, 1'b1, 1'b0});
    tick();
    chk("timeout", {27'd0, game_state, bus.move_req, timeout_err}, {27'd0, 3'd3, 1'b0, 1'b1});

    // Reset in the middle of a spawn
    press(4'b1000, "rst_up");
    done_pulse(1'b1);
    begin
      int n = 0;
      while (bus.rng_req !== 1'b1 && n < 20) begin
        tick();
        n++;
      end
    end
    chk("spawn_req_pre_rst", 32'(bus.rng_req), 32'd1);
    rst = 1'b1;
    tick();
    chk("rst_mid_spawn", {game_state, bus.rng_req, bus.move_req, bus.spawn_valid, timeout_err, move_count},
        32'd0);
    rst = 1'b0;
    tick();
    chk("idle_after_rst", 32'(game_state), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/game_sequencer.md
GAME_SEQUENCER -- requirements
Module: game_sequencer

Interface
REQ-001 Parameter BOARD_DIM, default 4: tiles per board side; board holds BOARD_DIM*BOARD_DIM cells.
REQ-002 Parameter TILE_W, default 4: width of a tile exponent (value 2^e; 0 = empty).
REQ-003 Parameter INIT_TILES, default 2: tiles spawned at game start, range 1..BOARD_DIM*BOARD_DIM.
REQ-004 Parameter WIN_EXP, default 11: exponent that wins the game (2^11 = 2048).
REQ-005 Parameter MOVE_TIMEOUT, default 255: maximum cycles to wait for board_done.
REQ-006 Derived LOC_W = clog2(BOARD_DIM*BOARD_DIM).
REQ-007 Clocking: one clock; reset is synchronous and active-high.
REQ-008 clk  in  1  system clock, all logic on rising edge.
REQ-009 rst  in  1  synchronous, active-high reset.
REQ-010 start  in  1  level; starts a game from IDLE/LOST, continues play from WON.
REQ-011 button_press  in  4  raw button levels; [3]=up [2]=down [1]=left [0]=right.
REQ-012 rng_req  out  1  request a random cell/value.
REQ-013 rng_valid  in  1  rng_location/rng_four valid this cycle.
REQ-014 rng_location  in  LOC_W  random empty-cell index.
REQ-015 rng_four  in  1  1 = spawn a 4, 0 = spawn a 2.
REQ-016 move_req  out  1  board move request, held until board_done.
REQ-017 move_dir  out  4  one-hot direction, same encoding as button_press.
REQ-018 board_done  in  1  board finished the move (one-cycle pulse).
REQ-019 board_changed  in  1  sampled with board_done; 1 = at least one tile moved or merged.
REQ-020 movable  in  1  some legal move exists on the current board.
REQ-021 empty_count  in  LOC_W+1  number of empty cells.
REQ-022 max_tile  in  TILE_W  largest exponent on the board.
REQ-023 spawn_valid  out  1  one-cycle pulse: write spawn_value at spawn_location.
REQ-024 spawn_location  out  LOC_W  target cell, valid with spawn_valid.
REQ-025 spawn_value  out  TILE_W  exponent 1 (2) or 2 (4), valid with spawn_valid.
REQ-026 game_state  out  3  current FSM state encoding.
REQ-027 move_count  out  16  accepted moves that changed the board, saturating.
REQ-028 timeout_err  out  1  sticky; set when a move times out.

Function
REQ-029 States/encoding: IDLE=0 INIT=1 CHECK=2 WAIT=3 MOVE=4 SPAWN=5 WON=6 LOST=7.
REQ-030 Buttons: two-register pipeline d1,d2; edge[i] = d1[i] & ~d2[i], registered; press accepted in WAIT only when exactly one edge bit is set; multi-bit edges are discarded.
REQ-031 IDLE: start=1 -> INIT; clear spawn counter, move_count, won_latched, timeout_err.
REQ-032 INIT/SPAWN: rng_req=1 while in state; on rng_valid, next cycle spawn_valid=1 with spawn_location=rng_location, spawn_value = rng_four ? 2 : 1; rng_req drops the same cycle spawn_valid rises.
REQ-033 INIT: counts spawns; after INIT_TILES spawns -> CHECK; empty_count=0 on entry to a spawn -> CHECK with no spawn.
REQ-034 SPAWN: single spawn then -> CHECK; empty_count=0 -> CHECK immediately.
REQ-035 CHECK (1 cycle): max_tile >= WIN_EXP and won_latched=0 -> WON; else movable=0 -> LOST; else -> WAIT.
REQ-036 WAIT: accepted press -> MOVE; move_dir latched from the edge; move_req rises on MOVE entry.
REQ-037 MOVE: move_req/move_dir held until board_done; board_changed=1 -> SPAWN and move_count+1 (saturating at 0xFFFF); board_changed=0 -> WAIT, no spawn, no count.
REQ-038 MOVE timeout: cycle counter reaches MOVE_TIMEOUT without board_done -> set timeout_err, drop move_req, -> WAIT.
REQ-039 WON: start=1 sets won_latched -> WAIT (play continues; win not reported again).
REQ-040 LOST: start=1 -> IDLE-equivalent clear, then INIT.
REQ-041 rng_valid, board_done outside their consuming states are ignored.

Reset
REQ-042 rst=1 at any clock edge, including mid-MOVE or mid-spawn: state=IDLE, all outputs 0, button pipeline and counters cleared; first active edge after rst falls is normal operation.

Verification
REQ-043 start=1, rng_valid after 2 cycles with loc 5/rng_four=0 then loc 9/rng_four=1 -> two spawn_valid pulses (5,1),(9,2), then CHECK -> WAIT.
REQ-044 WAIT, left button rises -> move_req=1, move_dir=4'b0010; board_done with board_changed=1 -> SPAWN, move_count=1.
REQ-045 Up and right rise the same cycle -> no move_req, stays WAIT; board_changed=0 move -> WAIT, move_count unchanged.
REQ-046 max_tile=11 in CHECK -> WON; start -> WAIT; max_tile still 11 -> stays WAIT; movable=0 -> LOST.
REQ-047 MOVE with no board_done for 255 cycles -> timeout_err=1, move_req=0, WAIT; rst mid-SPAWN -> IDLE, all outputs 0.
